// File: rtl/threat_pkg.sv
// Shared types and default constants for the threat detector.
// Holds the packet FSM state enum and the signature byte helper.
package threat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2
    } pkt_state_e;

    localparam logic [31:0] DEF_SIG          = 32'hDEADBEEF;
    localparam int          DEF_MAX_LEN      = 64;
    localparam logic [7:0]  DEF_BLOCKED_TYPE = 8'hFF;
    localparam int          DEF_RATE_LIMIT   = 8;
    localparam int          DEF_WINDOW       = 100;

    // Byte i of the signature, byte 0 being the most significant.
    function automatic logic [7:0] sig_byte(
        input logic [31:0] s,
        input logic [1:0]  i
    );
        unique case (i)
            2'd0:    sig_byte = s[31:24];
            2'd1:    sig_byte = s[23:16];
            2'd2:    sig_byte = s[15:8];
            default: sig_byte = s[7:0];
        endcase
    endfunction

endpackage

// File: rtl/sig_matcher.sv
// Four-byte signature matcher over an accepted byte stream.
// hit is combinational on the beat that completes the signature.
module sig_matcher
    import threat_pkg::*;
#(
    parameter logic [31:0] SIG = DEF_SIG
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       en,
    input  logic       clr,
    output logic       hit
);

    logic [1:0] cnt;
    logic [1:0] base;
    logic [1:0] cnt_d;
    logic       eq;
    logic       eq0;

    // A clear on the same beat makes this byte the first of a fresh match.
    always_comb begin
        base  = clr ? 2'd0 : cnt;
        eq    = (data == sig_byte(SIG, base));
        eq0   = (data == sig_byte(SIG, 2'd0));
        hit   = en && eq && (base == 2'd3);
        cnt_d = base;
        if (en) begin
            if (eq)
                cnt_d = (base == 2'd3) ? 2'd0 : base + 2'd1;
            else
                cnt_d = eq0 ? 2'd1 : 2'd0;
        end
    end

    // Matched-byte count register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 2'd0;
        else
            cnt <= cnt_d;
    end

endmodule

// File: rtl/threat_detector.sv
// Inline packet inspector: length, type, truncation and rate rules,
// plus signature detection, with registered violation pulses.
module threat_detector
    import threat_pkg::*;
#(
    parameter logic [31:0] SIG          = DEF_SIG,
    parameter int          MAX_LEN      = DEF_MAX_LEN,
    parameter logic [7:0]  BLOCKED_TYPE = DEF_BLOCKED_TYPE,
    parameter int          RATE_LIMIT   = DEF_RATE_LIMIT,
    parameter int          WINDOW       = DEF_WINDOW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        firewall_block,
    output logic        in_ready,
    output logic        rule_violation,
    output logic        pattern_violation,
    output logic [15:0] viol_count
);

    localparam int LW  = $clog2(MAX_LEN + 2);
    localparam int SCW = $clog2(RATE_LIMIT + 2);
    localparam int WW  = (WINDOW > 2) ? $clog2(WINDOW) : 1;

    localparam logic [LW-1:0]  MAXL  = LW'(MAX_LEN);
    localparam logic [SCW-1:0] RLIM  = SCW'(RATE_LIMIT);
    localparam logic [WW-1:0]  WLAST = WW'(WINDOW - 1);

    pkt_state_e      state, state_d;
    logic [LW-1:0]   len, len_d;
    logic            flagged, flagged_d;
    logic            pat_done, pat_done_d;
    logic [WW-1:0]   win, win_d;
    logic [SCW-1:0]  sop_cnt, sop_cnt_d;
    logic [SCW-1:0]  sop_base;

    logic acc;
    logic sop_acc;
    logic pkt_breach;
    logic rate_breach;
    logic m_en;
    logic m_clr;
    logic m_hit;
    logic pat_pulse;

    assign in_ready = !firewall_block;
    assign acc      = in_valid && !firewall_block;
    assign sop_acc  = acc && in_sop;

    sig_matcher #(
        .SIG (SIG)
    ) u_match (
        .clk  (clk),
        .rst  (rst),
        .data (in_data),
        .en   (m_en),
        .clr  (m_clr),
        .hit  (m_hit)
    );

    // Packet FSM: length/type/truncation checks and matcher steering.
    always_comb begin
        state_d    = state;
        len_d      = len;
        flagged_d  = flagged;
        pkt_breach = 1'b0;
        m_en       = 1'b0;
        m_clr      = 1'b0;
        if (acc) begin
            if (in_sop) begin
                m_clr      = 1'b1;
                m_en       = 1'b1;
                len_d      = LW'(1);
                pkt_breach = (in_data == BLOCKED_TYPE) ||
                             ((state != IDLE) && !flagged);
                flagged_d  = (in_data == BLOCKED_TYPE);
                state_d    = in_eop ? IDLE : PAYLOAD;
            end else begin
                unique case (state)
                    IDLE: ;
                    PAYLOAD: begin
                        if (len == MAXL) begin
                            pkt_breach = !flagged;
                            flagged_d  = 1'b1;
                            state_d    = in_eop ? IDLE : DISCARD;
                        end else begin
                            len_d   = len + LW'(1);
                            m_en    = 1'b1;
                            state_d = in_eop ? IDLE : PAYLOAD;
                        end
                    end
                    DISCARD: begin
                        if (in_eop)
                            state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Rate window: a sop on the wrap cycle counts into the new window.
    always_comb begin
        win_d       = (win == WLAST) ? '0 : win + WW'(1);
        sop_base    = (win == WLAST) ? '0 : sop_cnt;
        rate_breach = sop_acc && (sop_base == RLIM);
        sop_cnt_d   = sop_base;
        if (sop_acc && (sop_base <= RLIM))
            sop_cnt_d = sop_base + SCW'(1);
    end

    // One signature pulse per packet; a new sop re-arms it.
    always_comb begin
        pat_pulse  = m_hit && !(pat_done && !sop_acc);
        pat_done_d = sop_acc ? 1'b0 : pat_done;
        if (m_hit)
            pat_done_d = 1'b1;
    end

    // State registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            len               <= '0;
            flagged           <= 1'b0;
            pat_done          <= 1'b0;
            win               <= '0;
            sop_cnt           <= '0;
            rule_violation    <= 1'b0;
            pattern_violation <= 1'b0;
            viol_count        <= '0;
        end else begin
            state             <= state_d;
            len               <= len_d;
            flagged           <= flagged_d;
            pat_done          <= pat_done_d;
            win               <= win_d;
            sop_cnt           <= sop_cnt_d;
            rule_violation    <= pkt_breach || rate_breach;
            pattern_violation <= pat_pulse;
            if ((rule_violation || pattern_violation) &&
                (viol_count != 16'hFFFF))
                viol_count <= viol_count + 16'd1;
        end
    end

endmodule

// File: doc/threat_detector.md
THREAT_DETECTOR -- requirements
Module: threat_detector

Interface
REQ-001 SHALL have parameter SIG, default 32'hDEADBEEF: 4-byte signature, first byte = bits [31:24].
REQ-002 SHALL have parameter MAX_LEN, default 64: maximum legal packet length in bytes.
REQ-003 SHALL have parameter BLOCKED_TYPE, default 8'hFF: forbidden packet type byte.
REQ-004 SHALL have parameter RATE_LIMIT, default 8: maximum legal packet starts per window.
REQ-005 SHALL have parameter WINDOW, default 100: rate window length in clk cycles.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1: byte present on in_data.
REQ-009 SHALL have port in_data, input, 8: stream byte.
REQ-010 SHALL have port in_sop, input, 1: first byte of packet (type byte).
REQ-011 SHALL have port in_eop, input, 1: last byte of packet.
REQ-012 SHALL have port firewall_block, input, 1: isolate indication from downstream firewall FSM.
REQ-013 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-014 SHALL have port rule_violation, output, 1: one-cycle rule-breach pulse.
REQ-015 SHALL have port pattern_violation, output, 1: one-cycle signature-hit pulse.
REQ-016 SHALL have port viol_count, output, 16: saturating count of violation cycles.

Function
REQ-017 in_ready SHALL equal !firewall_block combinationally; beats offered while blocked are not consumed and have no effect.
REQ-018 Packet FSM SHALL have states IDLE, PAYLOAD, DISCARD; reset state IDLE.
REQ-019 IDLE: accepted beat with in_sop SHALL set len=1, go PAYLOAD (stay IDLE if in_eop also set); accepted beat without in_sop SHALL be ignored.
REQ-020 PAYLOAD: each accepted beat SHALL increment len; in_eop returns to IDLE.
REQ-021 Type byte equal to BLOCKED_TYPE SHALL flag a rule breach on that beat.
REQ-022 Accepting beat number MAX_LEN+1 of a packet SHALL flag a rule breach and go DISCARD; DISCARD drops beats until in_eop, then IDLE.
REQ-023 in_sop accepted in PAYLOAD or DISCARD SHALL flag a rule breach (truncated packet) and restart as a new packet with len=1.
REQ-024 Rate rule: free-running window counter wraps every WINDOW cycles, clearing the sop counter; the accepted sop that makes the count RATE_LIMIT+1 SHALL flag a rule breach, at most once per window.
REQ-025 rule_violation SHALL pulse high one cycle after the flagging beat; simultaneous breaches yield one pulse; at most one length/type/truncation pulse per packet.
REQ-026 Matcher SHALL track 0-3 matched signature bytes over all accepted bytes of a packet, including the type byte; on mismatch it SHALL re-test the byte against SIG[31:24]; it resets on every accepted sop.
REQ-027 The 4th consecutive match SHALL pulse pattern_violation one cycle later, at most once per packet; matching stops in DISCARD.
REQ-028 viol_count SHALL increment by 1 per cycle with either pulse high and saturate at 16'hFFFF.
REQ-029 All outputs except in_ready SHALL be registered.

Reset
REQ-030 On rst: state IDLE, len, matcher, window and sop counters 0; rule_violation, pattern_violation 0; viol_count 0.
REQ-031 rst mid-packet SHALL abandon the packet with no pulse; the next sop is treated as fresh.

Structure
REQ-032 Package threat_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-033 Signature matching SHALL be a sub-module sig_matcher (byte in, enable, clear, hit out).

Verification
REQ-034 Packet 01,DE,AD,BE,EF (eop on EF) -> one pattern_violation pulse the cycle after EF; no rule_violation; viol_count=1.
REQ-035 Packet DE,DE,AD,BE,EF -> match after overlap restart; single pattern pulse.
REQ-036 Type byte FF, 3-byte packet -> rule_violation one cycle after sop; only one pulse.
REQ-037 70-byte packet -> rule pulse after beat 65; beats 66-70 ignored; next packet is normal.
REQ-038 9 one-byte packets within 100 cycles -> one rule pulse after the 9th sop; after window wrap, 8 more packets give no pulse.
REQ-039 firewall_block=1 during stream -> in_ready=0, no state change; rst mid-packet -> all outputs 0, no pulse.
